instruction_loader: RTL

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/loader_pkg.sv | 33 +++
 rtl/word_serializer.sv | 62 ++++++
 rtl/instruction_loader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader.
//   - state_e           : loader FSM state encoding
//   - MEM_BYTES         : size of the instruction memory in bytes
//   - BYTES_PER_WORD    : bytes per instruction word
//   - MAX_WORDS         : words that fit in the memory
//   - be_byte()         : big-endian byte select of a 32-bit word
package loader_pkg;

  localparam int unsigned MEM_BYTES      = 256;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned MAX_WORDS      = MEM_BYTES / BYTES_PER_WORD;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Byte 0 is the most significant byte, matching the memory fetch order.
  function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      2'd3:    b = w[7:0];
      default: b = 8'd0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Holds one accepted instruction word and presents it one byte per cycle,
// most significant byte first, from a registered byte output.
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   load_i          : capture word_i/last_i, present byte 0
//   advance_i       : step to the next byte
//   clear_i         : drive the byte output to zero (no write in progress)
//   word_i, last_i  : word and final-word flag to capture
//   byte_o          : registered byte for the current write cycle
//   byte_idx_o      : index of the byte currently presented
//   last_o          : captured final-word flag
module word_serializer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        advance_i,
  input  logic        clear_i,
  input  logic [31:0] word_i,
  input  logic        last_i,
  output logic [7:0]  byte_o,
  output logic [1:0]  byte_idx_o,
  output logic        last_o
);

  logic [31:0] word_q;
  logic [1:0]  byte_idx_q;
  logic        last_q;
  logic [7:0]  byte_q;
  logic [1:0]  idx_next_s;

  assign idx_next_s = byte_idx_q + 2'd1;

  // Word capture, byte index and registered byte output.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q     <= 32'd0;
      byte_idx_q <= 2'd0;
      last_q     <= 1'b0;
      byte_q     <= 8'd0;
    end else if (load_i) begin
      word_q     <= word_i;
      last_q     <= last_i;
      byte_idx_q <= 2'd0;
      byte_q     <= be_byte(word_i, 2'd0);
    end else if (advance_i) begin
      byte_idx_q <= idx_next_s;
      byte_q     <= be_byte(word_q, idx_next_s);
    end else if (clear_i) begin
      byte_idx_q <= 2'd0;
      byte_q     <= 8'd0;
    end else begin
      byte_q     <= byte_q;
    end
  end

  assign byte_o     = byte_q;
  assign byte_idx_o = byte_idx_q;
  assign last_o     = last_q;

endmodule

// File: rtl/instruction_loader.sv
// Loads a stream of 32-bit instruction words into a 256-byte, byte-wide
// instruction memory, four big-endian byte writes per word.
// Ports:
//   clk, reset                 : clock and synchronous active-high reset
//   start, base_addr           : open a session at a word-aligned byte address
//   word_valid/word_data/word_last, word_ready : word stream handshake
//   mem_we, mem_addr, mem_wdata: byte write port to the instruction memory
//   busy, done, error          : session status (error is sticky)
//   word_count                 : words completely written this session
module instruction_loader
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  base_addr,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  input  logic        word_last,
  output logic        word_ready,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [6:0]  word_count
);

  state_e      state_q, state_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        error_q, error_d;
  logic [6:0]  count_q, count_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  mem_addr_q, mem_addr_d;

  logic        ser_load_s;
  logic        ser_adv_s;
  logic        ser_clear_s;
  logic [7:0]  ser_byte_s;
  logic [1:0]  ser_idx_s;
  logic        ser_last_s;
  logic [7:0]  ptr_next_s;

  assign ptr_next_s = ptr_q + 8'(BYTES_PER_WORD);

  word_serializer u_ser (
    .clk        (clk),
    .reset      (reset),
    .load_i     (ser_load_s),
    .advance_i  (ser_adv_s),
    .clear_i    (ser_clear_s),
    .word_i     (word_data),
    .last_i     (word_last),
    .byte_o     (ser_byte_s),
    .byte_idx_o (ser_idx_s),
    .last_o     (ser_last_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 8'd0;
      error_q    <= 1'b0;
      count_q    <= 7'd0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      error_q    <= error_d;
      count_q    <= count_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Next-state logic. The write-port registers are loaded one cycle ahead so
  // that mem_we/mem_addr/mem_wdata come straight from flops during WRITE.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    error_d     = error_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = 8'd0;
    ser_load_s  = 1'b0;
    ser_adv_s   = 1'b0;
    ser_clear_s = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          count_d = 7'd0;
          if (base_addr[1:0] == 2'b00) begin
            ptr_d   = base_addr;
            state_d = ST_ACCEPT;
          end else begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCEPT: begin
        if (word_valid) begin
          state_d     = ST_WRITE;
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q;
          ser_load_s  = 1'b1;
          ser_clear_s = 1'b0;
        end else begin
          state_d = ST_ACCEPT;
        end
      end

      ST_WRITE: begin
        if (ser_idx_s != 2'd3) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = mem_addr_q + 8'd1;
          ser_adv_s   = 1'b1;
          ser_clear_s = 1'b0;
        end else begin
          count_d = count_q + 7'd1;
          ptr_d   = ptr_next_s;
          if (ser_last_s) begin
            state_d = ST_DONE;
          end else if (ptr_next_s == 8'd0) begin
            // Word at 0xFC..0xFF was the final one that fits.
            error_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCEPT;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign word_ready = (state_q == ST_ACCEPT);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign error      = error_q;
  assign word_count = count_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = ser_byte_s;

endmodule
